dark_detect: RTL
================

DARK_DETECT -- requirements
Module: dark_detect

Interface
REQ-001 SHALL have parameter KH, default 10, meaning active lines per block row.
REQ-002 SHALL have parameter THRES, default 64, meaning 8-bit luma threshold; a pixel is dark when luma < THRES.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port hs_i  input  1  horizontal sync, active-high.
REQ-006 SHALL have port vs_i  input  1  vertical sync, active-high.
REQ-007 SHALL have port de_i  input  1  data enable, high on active pixels.
REQ-008 SHALL have port rgb_i  input  24  pixel, R[23:16], G[15:8], B[7:0].
REQ-009 SHALL have port hs_o  output  1  hs_i delayed 3 cycles.
REQ-010 SHALL have port vs_o  output  1  vs_i delayed 3 cycles.
REQ-011 SHALL have port de_o  output  1  de_i delayed 3 cycles.
REQ-012 SHALL have port rgb_o  output  24  rgb_i delayed 3 cycles.
REQ-013 SHALL have port wd_o  output  8  dark weight of the pixel on rgb_o, cycle-aligned with de_o.
REQ-014 SHALL have port freeze_o  output  1  block-row boundary flag, aligned to the delayed sync domain, feeds the block buffer freeze input.

Function
REQ-015 SHALL compute luma sum S = 77*R + 150*G + 29*B unsigned in 16 bits (max 65280, no overflow), Y = S[15:8].
REQ-016 SHALL pipeline luma in 3 register stages: stage 1 the three products, stage 2 S, stage 3 the compare and wd_o.
REQ-017 SHALL drive wd_o = 8'd1 when the delayed de is 1 and Y < THRES, else 8'd0; wd_o SHALL be 0 whenever de_o is 0.
REQ-018 SHALL delay hs, vs, de and rgb through 3-stage shift registers, so input at cycle n appears on the outputs at cycle n+3 with wd_o.
REQ-019 SHALL keep a line counter lc in 0..KH-1, advanced on each falling edge of the delayed de: wrap to 0 when lc == KH-1, else increment.
REQ-020 SHALL clear lc to 0 on each rising edge of the delayed vs.
REQ-021 SHALL set freeze_o to 1 in the cycle after a delayed-de falling edge seen with lc == KH-1.
REQ-022 SHALL clear freeze_o on the next delayed-de rising edge or delayed-vs rising edge, whichever comes first; freeze_o otherwise holds.
REQ-023 SHALL give the vs rising edge priority when it coincides with a de falling edge: lc = 0 and freeze_o = 0.
REQ-024 SHALL treat the comparison as strict: Y == THRES is not dark.
REQ-025 SHALL use edge detection that needs no extra input; the registered previous values come from the delay chain.

Reset
REQ-026 SHALL, while rst_ni = 0, asynchronously force all delay-chain stages, pipeline registers, lc, wd_o and freeze_o to 0.
REQ-027 SHALL, on release mid-line, resume with the first de rise seen after 3 cycles of valid pipeline; the partial line counts as one line at its de fall.
REQ-028 SHALL produce no wd_o = 1 and no freeze_o for 3 cycles after reset release.

Verification
REQ-029 Scenario: rgb_i = 0x000000 with de_i = 1 -> three cycles later de_o = 1 and wd_o = 1; rgb_i = 0xFFFFFF -> wd_o = 0.
REQ-030 Scenario: THRES = 64; rgb_i = 0x404040 (Y = 64) -> wd_o = 0; rgb_i = 0x3F3F3F (Y = 63) -> wd_o = 1.
REQ-031 Scenario: KH = 10, 25 lines of 16 active pixels after a vs pulse -> freeze_o pulses after lines 10 and 20, each pulse lasting until the next de rise; no pulse after line 25.
REQ-032 Scenario: vs pulse after line 7 -> lc reset; the next freeze_o comes after the 10th line following vs.
REQ-033 Scenario: de_i = 0 with rgb_i = 0 -> wd_o stays 0.
REQ-034 Scenario: rst_ni low for 2 cycles mid-line with freeze_o = 1 -> all outputs 0 immediately and freeze_o stays 0 until 10 more de falls.

Source files
------------

// File: rtl/dark_detect.sv
// rtl/dark_detect.sv - dark-pixel weight and block-row freeze flag on a 3-cycle delayed video stream
module dark_detect #(
    parameter int KH    = 10,
    parameter int THRES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [23:0] rgb_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] rgb_o,
    output logic [7:0]  wd_o,
    output logic        freeze_o
);

    localparam int              LCW    = (KH > 1) ? $clog2(KH) : 1;
    localparam logic [LCW-1:0]  LC_MAX = LCW'(KH - 1);
    localparam logic [8:0]      THR9   = 9'(THRES);

    logic [2:0]        r_hs_d;
    logic [2:0]        r_vs_d;
    logic [2:0]        r_de_d;
    logic [2:0][23:0]  r_rgb_d;
    logic [15:0]       r_pr;
    logic [15:0]       r_pg;
    logic [15:0]       r_pb;
    logic [15:0]       r_sum;
    logic [7:0]        r_wd;
    logic [LCW-1:0]    r_lc;
    logic              r_freeze;

    logic [15:0]       w_r16;
    logic [15:0]       w_g16;
    logic [15:0]       w_b16;
    logic              w_dark;
    logic              w_de_fall;
    logic              w_de_rise;
    logic              w_vs_rise;

    assign w_r16  = {8'd0, rgb_i[23:16]};
    assign w_g16  = {8'd0, rgb_i[15:8]};
    assign w_b16  = {8'd0, rgb_i[7:0]};
    assign w_dark = ({1'b0, r_sum[15:8]} < THR9);

    // Edges of the delayed syncs: stage 2 is what the outputs show next cycle, stage 3 what they show now.
    assign w_de_fall = r_de_d[2] & ~r_de_d[1];
    assign w_de_rise = ~r_de_d[2] & r_de_d[1];
    assign w_vs_rise = ~r_vs_d[2] & r_vs_d[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hs_d  <= '0;
            r_vs_d  <= '0;
            r_de_d  <= '0;
            r_rgb_d <= '0;
        end else begin
            r_hs_d  <= {r_hs_d[1:0], hs_i};
            r_vs_d  <= {r_vs_d[1:0], vs_i};
            r_de_d  <= {r_de_d[1:0], de_i};
            r_rgb_d <= {r_rgb_d[1:0], rgb_i};
        end
    end

    // Luma pipeline: products, sum, then compare gated by the de that lands on de_o with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pr  <= '0;
            r_pg  <= '0;
            r_pb  <= '0;
            r_sum <= '0;
            r_wd  <= '0;
        end else begin
            r_pr  <= w_r16 * 16'd77;
            r_pg  <= w_g16 * 16'd150;
            r_pb  <= w_b16 * 16'd29;
            r_sum <= r_pr + r_pg + r_pb;
            r_wd  <= {7'd0, r_de_d[1] & w_dark};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lc     <= '0;
            r_freeze <= 1'b0;
        end else if (w_vs_rise) begin
            r_lc     <= '0;
            r_freeze <= 1'b0;
        end else if (w_de_fall) begin
            if (r_lc == LC_MAX) begin
                r_lc     <= '0;
                r_freeze <= 1'b1;
            end else begin
                r_lc     <= r_lc + 1'b1;
            end
        end else if (w_de_rise) begin
            r_freeze <= 1'b0;
        end
    end

    assign hs_o     = r_hs_d[2];
    assign vs_o     = r_vs_d[2];
    assign de_o     = r_de_d[2];
    assign rgb_o    = r_rgb_d[2];
    assign wd_o     = r_wd;
    assign freeze_o = r_freeze;

endmodule
